// File: rtl/ste_automaton_engine.sv
// ste_automaton_engine: programmable STE array with report FIFO; REPORT_TIMESTAMP_EN adds symbol index to reports
module ste_automaton_engine #(
  parameter int N_STATES = 11,
  parameter int SYM_W = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W = 32,
  localparam int CI_W = (N_STATES > 1) ? $clog2(N_STATES) : 1,
  localparam int CB_W = (SYM_W > $clog2(N_STATES)) ? SYM_W : $clog2(N_STATES),
`ifdef REPORT_TIMESTAMP_EN
  localparam int REP_W = IDX_W + N_STATES
`else
  localparam int REP_W = N_STATES
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SYM_W-1:0]    symbol,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_type,
  input  logic [CI_W-1:0]     cfg_idx,
  input  logic [CB_W-1:0]     cfg_bit,
  input  logic [1:0]          cfg_val,
  output logic                rep_valid,
  input  logic                rep_ready,
  output logic [REP_W-1:0]    rep_data,
  output logic [N_STATES-1:0] active,
  output logic                overflow,
  output logic                cfg_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2**SYM_W-1:0] match_q [N_STATES];
  logic [N_STATES-1:0] adj_q [N_STATES];
  logic [1:0] st_q [N_STATES];
  logic [N_STATES-1:0] rmask_q, active_q, active_d, rpt;
  logic sod_q;
  logic [IDX_W-1:0] idx_q;
  logic [REP_W-1:0] mem_q [FIFO_DEPTH];
  logic [REP_W-1:0] ent;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic push, pop, acc, ovf_q, err_q;
  // next active vector: enabled by an active predecessor or a start condition, then filtered by the symbol class
  always_comb begin
    for (int i = 0; i < N_STATES; i++)
      active_d[i] = match_q[i][symbol] & (|(adj_q[i] & active_q) | st_q[i] == 2'd2 | (st_q[i] == 2'd1 & sod_q));
  end
  assign rpt = active_d & rmask_q;
  assign push = run & |rpt;
  assign pop = rep_valid & rep_ready;
  assign acc = push & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop);
`ifdef REPORT_TIMESTAMP_EN
  assign ent = {idx_q, rpt};
`else
  assign ent = rpt;
`endif
  assign rep_valid = cnt_q != '0;
  assign rep_data = rep_valid ? mem_q[rd_q] : '0;
  assign active = active_q;
  assign overflow = ovf_q;
  assign cfg_err = err_q;
  // configuration tables: writable only while idle, out-of-range targets silently ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STATES; i++) begin
        match_q[i] <= '0;
        adj_q[i] <= '0;
        st_q[i] <= '0;
      end
      rmask_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cfg_we & run) err_q <= 1'b1;
      if (cfg_we & ~run & (int'(cfg_idx) < N_STATES))
        case (cfg_type)
          2'd0: if (int'(cfg_bit) < 2**SYM_W) match_q[cfg_idx][cfg_bit[SYM_W-1:0]] <= cfg_val[0];
          2'd1: if (int'(cfg_bit) < N_STATES) adj_q[cfg_idx][cfg_bit[CI_W-1:0]] <= cfg_val[0];
          2'd2: st_q[cfg_idx] <= cfg_val;
          default: rmask_q[cfg_idx] <= cfg_val[0];
        endcase
    end
  end
  // automaton state advances only on run cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      sod_q <= 1'b1;
      idx_q <= '0;
    end else if (run) begin
      active_q <= active_d;
      sod_q <= 1'b0;
      idx_q <= idx_q + IDX_W'(1);
    end
  end
  // report FIFO: pop frees a slot before the same-cycle push is judged
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (pop) rd_q <= rd_q + AW'(1);
      if (acc) begin
        mem_q[wr_q] <= ent;
        wr_q <= wr_q + AW'(1);
      end
      if (push & ~acc) ovf_q <= 1'b1;
      cnt_q <= cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_ste_automaton_engine.sv
// tb_ste_automaton_engine: randomized and directed checks against a set-based automaton model
module tb_ste_automaton_engine;
  localparam int N = 11;
  localparam int DEPTH = 4;
`ifdef REPORT_TIMESTAMP_EN
  localparam int REP_W = 32 + N;
`else
  localparam int REP_W = N;
`endif
  logic clk = 0, reset = 0, run = 0, cfg_we = 0, rep_ready = 0;
  logic [7:0] symbol = 0, cfg_bit = 0;
  logic [1:0] cfg_type = 0, cfg_val = 0;
  logic [3:0] cfg_idx = 0;
  logic rep_valid, overflow, cfg_err;
  logic [REP_W-1:0] rep_data;
  logic [N-1:0] active;
  ste_automaton_engine #(.N_STATES(N), .SYM_W(8), .FIFO_DEPTH(DEPTH), .IDX_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .symbol(symbol), .cfg_we(cfg_we), .cfg_type(cfg_type),
    .cfg_idx(cfg_idx), .cfg_bit(cfg_bit), .cfg_val(cfg_val), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_data(rep_data), .active(active), .overflow(overflow), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  bit mm [N][256];
  bit ma [N][N];
  int ms [N];
  bit mr [N];
  logic [N-1:0] mact;
  bit msod, movf, merr;
  int unsigned midx;
  logic [REP_W-1:0] mq [$];
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mclear();
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 256; s++) mm[i][s] = 0;
      for (int j = 0; j < N; j++) ma[i][j] = 0;
      ms[i] = 0;
      mr[i] = 0;
    end
    mact = '0;
    msod = 1;
    movf = 0;
    merr = 0;
    midx = 0;
    mq.delete();
  endtask
  task automatic cyc(input bit r, input bit rn, input logic [7:0] sy, input bit we, input logic [1:0] ty,
                     input logic [3:0] ix, input logic [7:0] bt, input logic [1:0] vl, input bit rdy);
    bit pop, en;
    logic [N-1:0] nxt, rpt;
    @(negedge clk);
    reset = r; run = rn; symbol = sy; cfg_we = we; cfg_type = ty; cfg_idx = ix; cfg_bit = bt; cfg_val = vl; rep_ready = rdy;
    if (r) mclear();
    else begin
      pop = mq.size() > 0 && rdy;
      if (we && rn) merr = 1;
      else if (we && ix < N)
        case (ty)
          2'd0: mm[ix][bt] = vl[0];
          2'd1: if (bt < N) ma[ix][bt] = vl[0];
          2'd2: ms[ix] = int'(vl);
          default: mr[ix] = vl[0];
        endcase
      if (pop) void'(mq.pop_front());
      if (rn) begin
        for (int i = 0; i < N; i++) begin
          en = ms[i] == 2 || (ms[i] == 1 && msod);
          for (int j = 0; j < N; j++) if (ma[i][j] && mact[j]) en = 1;
          nxt[i] = en && mm[i][sy];
          rpt[i] = nxt[i] && mr[i];
        end
        if (rpt != 0) begin
          if (mq.size() < DEPTH)
`ifdef REPORT_TIMESTAMP_EN
            mq.push_back({midx, rpt});
`else
            mq.push_back(rpt);
`endif
          else movf = 1;
        end
        mact = nxt;
        msod = 0;
        midx++;
      end
    end
    @(posedge clk);
    #1;
    chk("active", active, mact);
    chk("rep_valid", rep_valid, mq.size() > 0);
    chk("rep_data", rep_data, mq.size() > 0 ? mq[0] : '0);
    chk("overflow", overflow, movf);
    chk("cfg_err", cfg_err, merr);
  endtask
  task automatic rst(); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic cfg(input logic [1:0] ty, input logic [3:0] ix, input logic [7:0] bt, input logic [1:0] vl);
    cyc(0, 0, 0, 1, ty, ix, bt, vl, 0);
  endtask
  task automatic go(input logic [7:0] sy, input bit rdy); cyc(0, 1, sy, 0, 0, 0, 0, 0, rdy); endtask
  task automatic idle(input bit rdy); cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy); endtask
  task automatic prog1();
    cfg(2, 0, 0, 1);
    cfg(0, 0, 8'h05, 1);
    cfg(1, 1, 0, 1);
    cfg(0, 1, 8'h07, 1);
    cfg(3, 1, 0, 1);
  endtask
  initial begin
    rst();
    chk("reset_data", rep_data, 0);
    prog1();
    cfg(3, 4'd13, 0, 1);
    cfg(1, 0, 8'd20, 1);
    go(8'h05, 0);
    go(8'h07, 0);
    chk("t1_valid", rep_valid, 1);
    chk("t1_rpt", rep_data[N-1:0], 11'b10);
`ifdef REPORT_TIMESTAMP_EN
    chk("t1_idx", rep_data[REP_W-1:N], 1);
`endif
    idle(1);
    go(8'h05, 0);
    go(8'h07, 0);
    chk("t3_noreport", rep_valid, 0);
    rst();
    prog1();
    go(8'h05, 0);
    idle(0);
    idle(0);
    chk("t6_hold", active, 11'b1);
    go(8'h07, 0);
    chk("t3_again", rep_data[N-1:0], 11'b10);
`ifdef REPORT_TIMESTAMP_EN
    chk("t6_idx", rep_data[REP_W-1:N], 1);
`endif
    rst();
    cfg(2, 2, 0, 2);
    cfg(0, 2, 8'h10, 1);
    cfg(0, 2, 8'h20, 1);
    cfg(3, 2, 0, 1);
    go(8'h10, 0);
    go(8'h90, 0);
    chk("t2_inactive", active, 0);
    go(8'h20, 0);
    idle(1);
    chk("t2_second", rep_data[N-1:0], 11'b100);
`ifdef REPORT_TIMESTAMP_EN
    chk("t2_idx", rep_data[REP_W-1:N], 2);
`endif
    idle(1);
    for (int k = 0; k < DEPTH; k++) go(8'h10, 0);
    chk("t4_full_noovf", overflow, 0);
    go(8'h10, 1);
    chk("t4_pushpop", overflow, 0);
    go(8'h10, 0);
    chk("t4_ovf", overflow, 1);
    cyc(0, 1, 8'h10, 1, 2'd2, 4'd0, 0, 2'd2, 0);
    chk("t5_err", cfg_err, 1);
    go(8'h77, 0);
    chk("t5_unchanged", active, 0);
    rst();
    chk("t5_rst_valid", rep_valid, 0);
    chk("t5_rst_err", cfg_err, 0);
    for (int i = 0; i < N; i++) begin
      cfg(2, 4'(i), 0, 2'($urandom_range(0, 3)));
      cfg(3, 4'(i), 0, 2'($urandom_range(0, 1)));
      for (int s = 0; s < 8; s++) cfg(0, 4'(i), 8'(s), 2'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 30; k++) cfg(1, 4'($urandom_range(0, N - 1)), 8'($urandom_range(0, N - 1)), 1);
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) cyc(0, 1, 8'($urandom_range(0, 7)), 1, 2'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), 2'($urandom), 1'($urandom));
      else if (r < 75) go(8'($urandom_range(0, 8)), 1'($urandom));
      else if (r < 85) cfg(2'($urandom), 4'($urandom), 8'($urandom_range(0, 12)), 2'($urandom));
      else idle(1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
